// File: rtl/ncu_sii_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ncu_sii_pkg
// Purpose : Shared types and constants for the NCU-side SII packet receiver.
//           Holds the receive FSM state encoding, packet geometry, header
//           field positions and the per-half parity check helper.
// Ports   : (package - none)
// Rev     : 1.0  initial release
// ============================================================================
package ncu_sii_pkg;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT  = 2'd1,
        ST_BEAT = 2'd2
    } state_e;

    // Packet geometry
    localparam int BEATS  = 4;
    localparam int BEAT_W = 32;
    localparam int PKT_W  = 128;
    localparam int HDR_W  = 16;

    // Beat 0 sits in the top 32 bits; the header is its low half
    localparam int HDR_POS_LSB = PKT_W - BEAT_W;

    // Header field positions within the 16-bit header
    localparam int HDR_TYPE_MSB = 15;
    localparam int HDR_TYPE_LSB = 13;
    localparam int HDR_ID_MSB   = 12;
    localparam int HDR_ID_LSB   = 9;
    localparam int HDR_INFO_MSB = 8;
    localparam int HDR_INFO_LSB = 0;

    // Returns 1 when the parity bit does not match its 16-bit half.
    // Even parity: dparity = XOR(half). Odd parity: dparity = ~XOR(half).
    function automatic logic half_perr(input logic [15:0] half,
                                       input logic        dpar,
                                       input logic        odd);
        return (^half) ^ odd ^ dpar;
    endfunction

endpackage : ncu_sii_pkg
`default_nettype wire

// File: rtl/ncu_sii_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ncu_sii_rx_fifo
// Purpose : Synchronous packet FIFO holding {perr, packet} entries.
// Ports   : iol2clk_i    - clock
//           reset_i      - synchronous active-high reset
//           push_i       - write push_data_i at the tail
//           push_data_i  - entry to write
//           pop_i        - drop the head entry (ignored when empty)
//           vld_o        - head entry valid
//           occ_o        - number of stored entries
//           head_o       - head entry, zero while empty
// Rev     : 1.0  initial release
// ============================================================================
module ncu_sii_rx_fifo
    import ncu_sii_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = PKT_W + 1,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             iol2clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             vld_o,
    output logic [OCC_W-1:0] occ_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [OCC_W-1:0] occ_q;
    logic             pop_ok_d;
    logic             push_ok_d;

    // Pointer increment with explicit wrap so non-power-of-two depths work
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok_d  = pop_i && (occ_q != '0);
        // A push into a full FIFO is only accepted when the head leaves
        // in the same cycle.
        push_ok_d = push_i && ((occ_q != OCC_W'(DEPTH)) || pop_ok_d);
    end

    always_ff @(posedge iol2clk_i) begin
        if (reset_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push_ok_d) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop_ok_d) begin
                rd_q <= next_ptr(rd_q);
            end
            case ({push_ok_d, pop_ok_d})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign vld_o  = (occ_q != '0);
    assign occ_o  = occ_q;
    // Mask the head when empty so stale entries never appear on the outputs
    assign head_o = vld_o ? mem_q[rd_q] : '0;

endmodule : ncu_sii_rx_fifo
`default_nettype wire

// File: rtl/ncu_sii_rx.sv
`default_nettype none
// ============================================================================
// Module  : ncu_sii_rx
// Purpose : Receives 4-beat packets from the SII: grants a request when the
//           packet FIFO has room, assembles the beats, checks per-half parity
//           and buffers completed packets for the downstream consumer.
// Ports   : iol2clk_i         - clock
//           reset_i           - synchronous active-high reset
//           sii_ncu_req_i     - SII has a packet
//           sii_ncu_data_i    - payload beat
//           sii_ncu_dparity_i - parity, [1] for data[31:16], [0] for [15:0]
//           ncu_sii_gnt_o     - one-cycle grant pulse
//           rx_vld_o          - head packet valid
//           rx_rdy_i          - consumer accepts head packet
//           rx_pkt_o          - head packet, beat 0 in [127:96]
//           rx_hdr_o          - head packet header
//           rx_perr_o         - head packet had a parity error
//           perr_sticky_o     - any parity error seen since reset
// Rev     : 1.0  initial release
// ============================================================================
module ncu_sii_rx
    import ncu_sii_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic               iol2clk_i,
    input  logic               reset_i,
    input  logic               sii_ncu_req_i,
    input  logic [BEAT_W-1:0]  sii_ncu_data_i,
    input  logic [1:0]         sii_ncu_dparity_i,
    output logic               ncu_sii_gnt_o,
    output logic               rx_vld_o,
    input  logic               rx_rdy_i,
    output logic [PKT_W-1:0]   rx_pkt_o,
    output logic [HDR_W-1:0]   rx_hdr_o,
    output logic               rx_perr_o,
    output logic               perr_sticky_o
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    state_e                      state_q;
    logic [1:0]                  cnt_q;
    logic                        gnt_q;
    logic [PKT_W-BEAT_W-1:0]     pkt_q;     // beats 0..2; beat 3 goes straight in
    logic                        perr_q;
    logic                        sticky_q;

    logic                        beat_err_d;
    logic                        push_d;
    logic [PKT_W:0]              push_data_d;
    logic                        space_d;

    logic [OCC_W-1:0]            occ;
    logic                        fifo_vld;
    logic [PKT_W:0]              fifo_head;

    always_comb begin
        beat_err_d  = half_perr(sii_ncu_data_i[31:16], sii_ncu_dparity_i[1], ODD_PARITY)
                    | half_perr(sii_ncu_data_i[15:0],  sii_ncu_dparity_i[0], ODD_PARITY);
        // Last beat is pushed in the cycle it is sampled
        push_d      = (state_q == ST_BEAT) && (cnt_q == 2'(BEATS - 1));
        push_data_d = {perr_q | beat_err_d, pkt_q, sii_ncu_data_i};
        // Occupancy already includes a packet pushed at the previous edge,
        // so at most one transfer can ever be in flight toward a free slot.
        space_d     = (occ < OCC_W'(FIFO_DEPTH));
    end

    always_ff @(posedge iol2clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b0;
            pkt_q    <= '0;
            perr_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            gnt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sii_ncu_req_i && space_d) begin
                        state_q <= ST_GNT;
                        gnt_q   <= 1'b1;
                    end
                end
                ST_GNT: begin
                    state_q <= ST_BEAT;
                    cnt_q   <= '0;
                    perr_q  <= 1'b0;
                end
                ST_BEAT: begin
                    pkt_q  <= {pkt_q[PKT_W-2*BEAT_W-1:0], sii_ncu_data_i};
                    perr_q <= perr_q | beat_err_d;
                    if (beat_err_d) begin
                        sticky_q <= 1'b1;
                    end
                    if (cnt_q == 2'(BEATS - 1)) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    ncu_sii_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PKT_W + 1)
    ) u_fifo (
        .iol2clk_i   (iol2clk_i),
        .reset_i     (reset_i),
        .push_i      (push_d),
        .push_data_i (push_data_d),
        .pop_i       (rx_rdy_i),
        .vld_o       (fifo_vld),
        .occ_o       (occ),
        .head_o      (fifo_head)
    );

    assign ncu_sii_gnt_o = gnt_q;
    assign perr_sticky_o = sticky_q;
    assign rx_vld_o      = fifo_vld;
    assign rx_perr_o     = fifo_head[PKT_W];
    assign rx_pkt_o      = fifo_head[PKT_W-1:0];
    assign rx_hdr_o      = {fifo_head[HDR_POS_LSB+HDR_TYPE_MSB : HDR_POS_LSB+HDR_TYPE_LSB],
                            fifo_head[HDR_POS_LSB+HDR_ID_MSB   : HDR_POS_LSB+HDR_ID_LSB],
                            fifo_head[HDR_POS_LSB+HDR_INFO_MSB : HDR_POS_LSB+HDR_INFO_LSB]};

endmodule : ncu_sii_rx
`default_nettype wire
